// File: rtl/uart_pkg.sv
// uart_pkg: shared opcodes, transmitter state type and frame constants for the UART command link
package uart_pkg;
    localparam int FRAME_DATA_BITS = 8;
    localparam logic [3:0] CMD_CLEAR = 4'b0001;
    localparam logic [3:0] CMD_LOAD = 4'b0010;
    localparam logic [3:0] CMD_SHOW = 4'b0100;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two synchronous FIFO with occupancy count and pointer-only flush on reset
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_push = push && count != CW'(DEPTH);
    assign do_pop = pop && count != '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    always_ff @(posedge clock)
        if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_cmd_tx.sv
// uart_cmd_tx: buffers command bytes and serializes them as start/8-data/stop frames on a registered line
module uart_cmd_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int STOP_BITS = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          serial,
    output logic          busy,
    output logic [CW-1:0] fifo_count
);
    localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int SW = STOP_BITS > 1 ? $clog2(STOP_BITS) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);
    localparam logic [2:0] BIT_LAST = 3'(FRAME_DATA_BITS - 1);
    tx_state_t state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0] idx, idx_n;
    logic [SW-1:0] stop, stop_n;
    logic [7:0] shift, shift_n, head;
    logic serial_n, pop, bit_done;
    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock(clock),
        .reset_n(reset_n),
        .push(in_valid && in_ready),
        .pop(pop),
        .din(in_data),
        .dout(head),
        .count(fifo_count)
    );
    assign in_ready = reset_n && fifo_count != CW'(FIFO_DEPTH);
    assign busy = state != IDLE;
    assign bit_done = baud == BAUD_LAST;
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state <= IDLE;
            baud <= '0;
            idx <= '0;
            stop <= '0;
            shift <= '0;
            serial <= 1'b1;
        end else begin
            state <= state_n;
            baud <= baud_n;
            idx <= idx_n;
            stop <= stop_n;
            shift <= shift_n;
            serial <= serial_n;
        end
    always_comb begin
        state_n = state;
        baud_n = state == IDLE ? baud : (bit_done ? '0 : baud + 1'b1);
        idx_n = idx;
        stop_n = stop;
        shift_n = shift;
        serial_n = serial;
        pop = 1'b0;
        case (state)
            IDLE: if (fifo_count != '0) begin
                pop = 1'b1;
                shift_n = head;
                serial_n = 1'b0;
                state_n = START;
            end
            START: if (bit_done) begin
                serial_n = shift[0];
                idx_n = '0;
                state_n = DATA;
            end
            DATA: if (bit_done) begin
                if (idx == BIT_LAST) begin
                    serial_n = 1'b1;
                    stop_n = '0;
                    state_n = STOP;
                end else begin
                    idx_n = idx + 1'b1;
                    shift_n = shift >> 1;
                    serial_n = shift[1];
                end
            end
            STOP: if (bit_done) begin
                // last stop cycle chains straight into the next start bit when data is waiting
                if (stop == STOP_LAST) begin
                    pop = fifo_count != '0;
                    state_n = pop ? START : IDLE;
                    shift_n = pop ? head : shift;
                    serial_n = !pop;
                end else stop_n = stop + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_cmd_tx.sv
// tb_uart_cmd_tx: frame-level reference model, line decoder and directed vectors for uart_cmd_tx
module tb_uart_cmd_tx;
    import uart_pkg::*;
    localparam int DEPTH = 4;
    localparam int SB = 2;
    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;
    } vec_t;
    logic clock = 1'b0, reset_n = 1'b0;
    logic [7:0] in_data = '0, in_data4 = '0;
    logic in_valid = 1'b0, in_valid4 = 1'b0;
    logic in_ready, serial, busy, in_ready4, serial4, busy4;
    logic [2:0] fifo_count, fifo_count4;
    int checks = 0, failures = 0;
    logic chk_en = 1'b0, stalled = 1'b0;
    logic [2:0] stall_cnt = '0;
    logic [7:0] mq[$], acc_log[$], rx_log[$];
    logic ml[$];
    int mp = 0;
    logic [7:0] mb;
    vec_t vecs[6];
    always #5 clock = ~clock;
    uart_cmd_tx dut (
        .clock(clock), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .serial(serial), .busy(busy), .fifo_count(fifo_count)
    );
    uart_cmd_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut4 (
        .clock(clock), .reset_n(reset_n), .in_data(in_data4), .in_valid(in_valid4),
        .in_ready(in_ready4), .serial(serial4), .busy(busy4), .fifo_count(fifo_count4)
    );
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask
    // expected line waveform: each popped byte appends its whole frame, one entry per clock
    always @(posedge clock or negedge reset_n) begin : model
        logic acc;
        logic [7:0] b;
        if (!reset_n) begin
            mq.delete();
            ml.delete();
        end else begin
            acc = in_valid && mq.size() != DEPTH;
            if (ml.size() != 0) void'(ml.pop_front());
            if (ml.size() == 0 && mq.size() != 0) begin
                b = mq.pop_front();
                ml.push_back(1'b0);
                for (int i = 0; i < 8; i++) ml.push_back(b[i]);
                for (int i = 0; i < SB; i++) ml.push_back(1'b1);
            end
            if (acc) begin
                mq.push_back(in_data);
                acc_log.push_back(in_data);
            end
        end
    end
    always @(negedge clock)
        if (reset_n && chk_en) begin
            check("model serial", serial, ml.size() != 0 ? ml[0] : 1'b1);
            check("model busy", busy, ml.size() != 0);
            check("model count", fifo_count, mq.size());
            check("model ready", in_ready, mq.size() != DEPTH);
        end
    always @(negedge clock)
        if (!reset_n) mp = 0;
        else if (mp == 0) begin
            if (serial == 1'b0) mp = 1;
        end else if (mp <= 8) begin
            mb[mp-1] = serial;
            mp++;
        end else begin
            check("rx stop bit", serial, 1'b1);
            if (mp == 10) begin
                rx_log.push_back(mb);
                mp = 0;
            end else mp++;
        end
    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            stalled = 1'b1;
            stall_cnt = fifo_count;
            @(negedge clock);
            n++;
        end
        check("push accepted", in_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while ((busy || fifo_count != 0) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check("drain idle", busy, 1'b0);
        repeat (2) @(negedge clock);
    endtask
    task automatic capture(input string name, input logic [10:0] frame);
        for (int i = 0; i < 11; i++) begin
            @(posedge clock);
            #1;
            check({name, " serial"}, serial, frame[10-i]);
            check({name, " busy"}, busy, 1'b1);
        end
        @(posedge clock);
        #1;
        check({name, " end busy"}, busy, 1'b0);
        check({name, " end serial"}, serial, 1'b1);
        @(negedge clock);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
    initial begin
        logic [7:0] d4, disp;
        logic [3:0] val;
        vecs[0] = '{8'h25, 11'b0_10100100_11};
        vecs[1] = '{8'h40, 11'b0_00000010_11};
        vecs[2] = '{8'h13, 11'b0_11001000_11};
        vecs[3] = '{8'hFF, 11'b0_11111111_11};
        vecs[4] = '{8'h00, 11'b0_00000000_11};
        vecs[5] = '{8'h0F, 11'b0_11110000_11};
        repeat (2) @(negedge clock);
        check("reset ready", in_ready, 1'b0);
        check("reset serial", serial, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset count", fifo_count, 0);
        reset_n = 1'b1;
        #1;
        check("release ready", in_ready, 1'b1);
        @(negedge clock);
        chk_en = 1'b1;
        foreach (vecs[v]) begin
            push_byte(vecs[v].data);
            capture($sformatf("vec%0d", v), vecs[v].frame);
        end
        rx_log.delete();
        push_byte(8'h25);
        push_byte(8'h40);
        for (int i = 0; i < 21; i++) begin
            @(posedge clock);
            #1;
            check("b2b gapless busy", busy, 1'b1);
        end
        drain();
        check("b2b frames", rx_log.size(), 2);
        val = '0;
        disp = 8'hFF;
        foreach (rx_log[i])
            if (rx_log[i][7:4] == CMD_CLEAR) val = '0;
            else if (rx_log[i][7:4] == CMD_LOAD) val = rx_log[i][3:0];
            else if (rx_log[i][7:4] == CMD_SHOW) disp = {4'(val / 10), 4'(val % 10)};
        check("b2b display", disp, 8'h05);
        rx_log.delete();
        stalled = 1'b0;
        for (int j = 0; j < 6; j++) push_byte(8'h11 + 8'(j));
        drain();
        check("six stalled", stalled, 1'b1);
        check("six stall count", stall_cnt, 4);
        check("six frames", rx_log.size(), 6);
        foreach (rx_log[i]) check("six order", rx_log[i], 8'h11 + 8'(i));
        d4 = 8'hA3;
        check("dut4 ready", in_ready4, 1'b1);
        in_data4 = d4;
        in_valid4 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid4 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            check("dut4 serial", serial4, i < 4 ? 1'b0 : i >= 36 ? 1'b1 : d4[i/4-1]);
            check("dut4 busy", busy4, 1'b1);
        end
        check("dut4 count", fifo_count4, 0);
        @(posedge clock);
        #1;
        check("dut4 end busy", busy4, 1'b0);
        check("dut4 end serial", serial4, 1'b1);
        @(negedge clock);
        rx_log.delete();
        push_byte(8'h52);
        push_byte(8'hC3);
        repeat (4) @(posedge clock);
        #2;
        check("pre-reset bit3", serial, 1'b0);
        reset_n = 1'b0;
        #1;
        check("async serial", serial, 1'b1);
        check("async ready", in_ready, 1'b0);
        check("async busy", busy, 1'b0);
        check("async count", fifo_count, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("post-reset ready", in_ready, 1'b1);
        check("post-reset count", fifo_count, 0);
        push_byte(8'h0F);
        capture("after reset", 11'b0_11110000_11);
        drain();
        check("after reset frames", rx_log.size(), 1);
        foreach (rx_log[i]) check("after reset byte", rx_log[i], 8'h0F);
        acc_log.delete();
        rx_log.delete();
        for (int c = 0; c < 600; c++) begin
            @(negedge clock);
            in_valid = $urandom_range(0, 15) < (c < 300 ? 12 : 1);
            in_data = 8'($urandom);
        end
        @(negedge clock);
        in_valid = 1'b0;
        drain();
        check("random frames", rx_log.size(), acc_log.size());
        foreach (rx_log[i]) if (i < acc_log.size()) check("random byte", rx_log[i], acc_log[i]);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
